// File: rtl/screen_sequencer.sv
// Game-phase sequencer: IDLE -> GET_READY -> PLAY -> TIMES_UP -> LEADERBOARD.
// Drives one-hot overlay selects, the play-clock seconds count and a round_done pulse.
module screen_sequencer #(
  parameter int FPS            = 60,
  parameter int READY_FRAMES   = 180,
  parameter int PLAY_SECONDS   = 60,
  parameter int TIMESUP_FRAMES = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       abort,
  output logic       get_ready,
  output logic       times_up,
  output logic       leaderboard,
  output logic       playing,
  output logic [6:0] seconds_left,
  output logic       round_done
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_GET_READY   = 3'd1,
    S_PLAY        = 3'd2,
    S_TIMES_UP    = 3'd3,
    S_LEADERBOARD = 3'd4
  } state_t;

  localparam logic [8:0] READY_LAST   = 9'(READY_FRAMES - 1);
  localparam logic [8:0] TIMESUP_LAST = 9'(TIMESUP_FRAMES - 1);
  localparam logic [5:0] FPS_LAST     = 6'(FPS - 1);
  localparam logic [6:0] PLAY_LOAD    = 7'(PLAY_SECONDS);

  state_t     state_q, state_d;
  logic [8:0] frame_cnt_q, frame_cnt_d;
  logic [5:0] sec_div_q, sec_div_d;
  logic [6:0] seconds_left_q, seconds_left_d;
  logic       get_ready_q, get_ready_d;
  logic       times_up_q, times_up_d;
  logic       leaderboard_q, leaderboard_d;
  logic       playing_q, playing_d;
  logic       round_done_q, round_done_d;

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    sec_div_d      = sec_div_q;
    seconds_left_d = seconds_left_q;
    round_done_d   = 1'b0;

    if (abort) begin
      state_d        = S_IDLE;
      frame_cnt_d    = '0;
      sec_div_d      = '0;
      seconds_left_d = PLAY_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A frame_tick coincident with start is deliberately not counted.
          if (start) begin
            state_d     = S_GET_READY;
            frame_cnt_d = '0;
          end
        end
        S_GET_READY: begin
          if (frame_tick) begin
            if (frame_cnt_q == READY_LAST) begin
              state_d        = S_PLAY;
              frame_cnt_d    = '0;
              sec_div_d      = '0;
              seconds_left_d = PLAY_LOAD;
            end else begin
              frame_cnt_d = frame_cnt_q + 9'd1;
            end
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (sec_div_q == FPS_LAST) begin
              sec_div_d = '0;
              if (seconds_left_q != 7'd0) begin
                seconds_left_d = seconds_left_q - 7'd1;
              end
              if (seconds_left_q <= 7'd1) begin
                state_d      = S_TIMES_UP;
                frame_cnt_d  = '0;
                round_done_d = 1'b1;
              end
            end else begin
              sec_div_d = sec_div_q + 6'd1;
            end
          end
        end
        S_TIMES_UP: begin
          seconds_left_d = '0;
          if (frame_tick) begin
            if (frame_cnt_q == TIMESUP_LAST) begin
              state_d     = S_LEADERBOARD;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 9'd1;
            end
          end
        end
        S_LEADERBOARD: begin
          if (start) begin
            state_d     = S_GET_READY;
            frame_cnt_d = '0;
          end
        end
        default: begin
          state_d        = S_IDLE;
          frame_cnt_d    = '0;
          sec_div_d      = '0;
          seconds_left_d = PLAY_LOAD;
        end
      endcase
    end

    // Selects follow next-state so they flip on the same edge as the state register.
    get_ready_d   = (state_d == S_GET_READY);
    times_up_d    = (state_d == S_TIMES_UP);
    leaderboard_d = (state_d == S_LEADERBOARD);
    playing_d     = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      sec_div_q      <= '0;
      seconds_left_q <= PLAY_LOAD;
      get_ready_q    <= 1'b0;
      times_up_q     <= 1'b0;
      leaderboard_q  <= 1'b0;
      playing_q      <= 1'b0;
      round_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      sec_div_q      <= sec_div_d;
      seconds_left_q <= seconds_left_d;
      get_ready_q    <= get_ready_d;
      times_up_q     <= times_up_d;
      leaderboard_q  <= leaderboard_d;
      playing_q      <= playing_d;
      round_done_q   <= round_done_d;
    end
  end

  assign get_ready    = get_ready_q;
  assign times_up     = times_up_q;
  assign leaderboard  = leaderboard_q;
  assign playing      = playing_q;
  assign seconds_left = seconds_left_q;
  assign round_done   = round_done_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: a fast-parameter instance for round timing
// and a default-parameter instance for reset values.
module tb_screen_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       start;
  logic       abort;

  logic       get_ready, times_up, leaderboard, playing, round_done;
  logic [6:0] seconds_left;
  logic       d_get_ready, d_times_up, d_leaderboard, d_playing, d_round_done;
  logic [6:0] d_seconds_left;

  int vectors_q = 0;
  int miscompares_q = 0;
  logic onehot_en = 1'b0;

  always #5 clk = ~clk;

  screen_sequencer #(
    .FPS(4), .READY_FRAMES(3), .PLAY_SECONDS(2), .TIMESUP_FRAMES(2)
  ) u_dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start), .abort(abort),
    .get_ready(get_ready), .times_up(times_up), .leaderboard(leaderboard),
    .playing(playing), .seconds_left(seconds_left), .round_done(round_done)
  );

  screen_sequencer u_dut_def (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start), .abort(abort),
    .get_ready(d_get_ready), .times_up(d_times_up), .leaderboard(d_leaderboard),
    .playing(d_playing), .seconds_left(d_seconds_left), .round_done(d_round_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_q++;
    if (got !== exp) begin
      miscompares_q++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (onehot_en) begin
      chk("onehot", 32'(get_ready) + 32'(times_up) + 32'(leaderboard) <= 32'd1, 32'd1);
    end
  end

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; start = 1'b0; abort = 1'b0;
    step(); step();
    chk("rst_gr", get_ready, 0);
    chk("rst_tu", times_up, 0);
    chk("rst_lb", leaderboard, 0);
    chk("rst_play", playing, 0);
    chk("rst_rd", round_done, 0);
    chk("rst_sl", seconds_left, 2);
    chk("rst_sl_def", d_seconds_left, 60);
    resetn = 1'b1;
    step();
    onehot_en = 1'b1;

    // Full round
    start = 1'b1; step(); start = 1'b0;
    chk("start_gr", get_ready, 1);
    chk("start_play", playing, 0);
    frame(); chk("idle_cycle_gr", get_ready, 1);
    step(); chk("no_tick_gr", get_ready, 1);
    for (int i = 2; i <= 3; i++) begin
      frame();
      chk("gr_phase", get_ready, (i < 3) ? 1 : 0);
      chk("gr_to_play", playing, (i == 3) ? 1 : 0);
    end
    chk("play_load", seconds_left, 2);
    for (int i = 1; i <= 8; i++) begin
      frame();
      chk("play_sl", seconds_left, (i < 4) ? 2 : ((i < 8) ? 1 : 0));
      chk("play_on", playing, (i < 8) ? 1 : 0);
      chk("play_rd", round_done, (i == 8) ? 1 : 0);
      chk("play_tu", times_up, (i == 8) ? 1 : 0);
    end
    step();
    chk("rd_one_cycle", round_done, 0);
    chk("tu_hold", times_up, 1);
    frame(); chk("tu_tick1", times_up, 1);
    frame();
    chk("tu_done", times_up, 0);
    chk("lb_enter", leaderboard, 1);
    for (int i = 0; i < 100; i++) begin
      frame();
      chk("lb_hold", leaderboard, 1);
      chk("lb_sl", seconds_left, 0);
    end

    // New round from LEADERBOARD, start during PLAY ignored
    start = 1'b1; step(); start = 1'b0;
    chk("lb_start_gr", get_ready, 1);
    chk("lb_start_lb", leaderboard, 0);
    for (int i = 0; i < 3; i++) frame();
    chk("r2_play", playing, 1);
    chk("r2_sl", seconds_left, 2);
    start = 1'b1; step(); start = 1'b0;
    chk("play_start_ign", playing, 1);
    chk("play_start_gr", get_ready, 0);
    for (int i = 0; i < 7; i++) frame();
    chk("pre_abort_sl", seconds_left, 1);

    // Abort on the expiring tick
    abort = 1'b1; frame_tick = 1'b1; step(); abort = 1'b0; frame_tick = 1'b0;
    chk("abort_play", playing, 0);
    chk("abort_tu", times_up, 0);
    chk("abort_rd", round_done, 0);
    chk("abort_sl", seconds_left, 2);
    step();
    chk("abort_rd_after", round_done, 0);
    frame(); frame();
    chk("idle_tick_ign", get_ready, 0);

    // start + frame_tick together in IDLE
    start = 1'b1; frame_tick = 1'b1; step(); start = 1'b0; frame_tick = 1'b0;
    chk("coinc_gr", get_ready, 1);
    frame(); frame();
    chk("coinc_gr2", get_ready, 1);
    chk("coinc_play2", playing, 0);
    frame();
    chk("coinc_play3", playing, 1);

    // Mid-PLAY reset of the default instance
    onehot_en = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 185; i++) frame();
    chk("def_playing", d_playing, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_play_def", d_playing, 0);
    chk("mid_rst_sl_def", d_seconds_left, 60);
    chk("mid_rst_sel_def", {d_get_ready, d_times_up, d_leaderboard, d_round_done}, 0);
    chk("mid_rst_sl", seconds_left, 2);
    chk("mid_rst_lb", leaderboard, 0);
    step();
    resetn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_q, miscompares_q);
    $finish;
  end

endmodule
